multi_zone_alarm: RTL and testbench
===================================

// Module: multi_zone_alarm
// PURPOSE
//  N-zone intrusion alarm controller, parametrised successor to the single-sensor alarm FSM.
//  Adds an entry-delay window before sounding, an auto-silence timeout, and a per-zone trip record.
//  Sits between debounced zone sensors / keypad strobes and the buzzer driver; runs on the 0.1 s tick clock.
// PARAMETERS
//  N_ZONES     4    number of sensor zones (1..16)
//  CNT_W       8    width of the shared delay/timeout counter
//  ENTRY_DLY   50   clk cycles in PENDING before ALARM (1..2**CNT_W-1)
//  ALARM_TIME  200  clk cycles of buzzing before auto-silence (1..2**CNT_W-1)
// PORTS
//  clk         in   1        system clock (0.1 s tick)
//  rst         in   1        reset, asynchronous, active-high
//  sensor      in   N_ZONES  zone sensors, 1 = tripped, synchronous to clk
//  start       in   1        arm request (level, sampled each clk)
//  cancel      in   1        disarm request (level)
//  test        in   1        buzzer self-test request (level)
//  buzz        out  1        buzzer drive
//  armed       out  1        1 in ARMED/PENDING/ALARM/SILENT
//  state_o     out  3        current state encoding (for display/debug)
//  zone_hit    out  N_ZONES  tripped-zone record (ALARM_LATCH_EN only)
// BEHAVIOUR
//  - One clock, async active-high rst. On rst: state=IDLE, cnt=0, buzz=0, armed=0, zone_hit=0.
//  - States (state_o): IDLE=0, ARMED=1, PENDING=2, ALARM=3, SILENT=4, TEST=5; codes 6/7 -> IDLE next clk, cnt=0.
//  - All outputs Moore-decoded from registered state; response appears the clk after the causing input.
//  - cancel has priority over every other condition in every non-IDLE state: -> IDLE, cnt=0.
//  - IDLE: start -> ARMED; else test -> TEST; start wins if both high. cnt held at 0.
//  - ARMED: |sensor -> PENDING, cnt=0. Sensors already high on entry trip on the next clk.
//  - PENDING: cnt increments each clk; at cnt==ENTRY_DLY-1 -> ALARM, cnt=0.
//    Sensors clearing during PENDING do NOT abort; only cancel does.
//  - ALARM: buzz=1; cnt increments; at cnt==ALARM_TIME-1 -> SILENT, cnt=0.
//  - SILENT: buzz=0; sensor==0 (all zones) -> ARMED; any zone high -> stay SILENT (no re-trigger
//    while a zone remains tripped; re-arm only via clear).
//  - TEST: buzz=1 until cancel; start/test/sensor ignored.
//  - buzz=1 exactly in ALARM and TEST. armed=1 in ARMED, PENDING, ALARM, SILENT.
//  - Counter is CNT_W wide, never wraps: compare-and-reset only; ENTRY_DLY=1 gives one PENDING cycle.
//  - Simultaneous cancel+sensor in ARMED -> IDLE. rst mid-sequence aborts immediately, no pending state kept.
// CONFIGURATION
//  - Macro MULTI_ZONE_ALARM_LATCH_EN defined: zone_hit port present; each bit ORs in sensor[i]
//    every clk while state is ARMED, PENDING, ALARM or SILENT; cleared on entry to IDLE
//    (cancel) and on rst; NOT cleared by SILENT->ARMED, so the record survives re-arm.
//  - Macro undefined: zone_hit port and its register are absent; all other behaviour identical.
// TESTING
//  1. rst, start=1 1clk, sensor=4'b0010 at t0 -> PENDING t0+1, ALARM/buzz=1 at t0+51, buzz=0 at t0+251.
//  2. In PENDING at cnt=20, cancel=1 -> IDLE next clk, buzz never asserts, armed=0, zone_hit=0.
//  3. SILENT with sensor=4'b0001 held 10 clks -> stays SILENT; sensor=0 -> ARMED next clk.
//  4. IDLE, start=1 and test=1 same clk -> ARMED (not TEST); later test alone from IDLE -> buzz=1 until cancel.
//  5. Trip zone 1 then zone 3 during PENDING -> zone_hit=4'b1010 (LATCH_EN); persists through SILENT->ARMED.
//  6. Assert rst asynchronously mid-ALARM -> buzz=0, state_o=0 without waiting for a clk edge.

Source files
------------

// File: rtl/multi_zone_alarm.sv
// N-zone intrusion alarm FSM with entry delay, auto-silence timeout and optional trip record.
// Define MULTI_ZONE_ALARM_LATCH_EN to add the zone_hit port and its per-zone latch.
module multi_zone_alarm #(
   parameter int N_ZONES    = 4,
   parameter int CNT_W      = 8,
   parameter int ENTRY_DLY  = 50,
   parameter int ALARM_TIME = 200
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_ZONES-1:0] sensor,
   input  logic               start,
   input  logic               cancel,
   input  logic               test,
   output logic               buzz,
   output logic               armed,
   output logic [2:0]         state_o
`ifdef MULTI_ZONE_ALARM_LATCH_EN
   ,
   output logic [N_ZONES-1:0] zone_hit
`endif
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARMED   = 3'd1;
   localparam logic [2:0] PENDING = 3'd2;
   localparam logic [2:0] ALARM   = 3'd3;
   localparam logic [2:0] SILENT  = 3'd4;
   localparam logic [2:0] TEST    = 3'd5;

   localparam logic [CNT_W-1:0] ENTRY_LAST = CNT_W'(ENTRY_DLY - 1);
   localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_TIME - 1);

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_comb begin
      state_nx = state;
      cnt_nx   = '0;
      case (state)
         IDLE: begin
            if (start)     state_nx = ARMED;
            else if (test) state_nx = TEST;
         end
         ARMED: begin
            if (cancel)       state_nx = IDLE;
            else if (|sensor) state_nx = PENDING;
         end
         PENDING: begin
            if (cancel)                 state_nx = IDLE;
            else if (cnt == ENTRY_LAST) state_nx = ALARM;
            else                        cnt_nx   = cnt + CNT_W'(1);
         end
         ALARM: begin
            if (cancel)                 state_nx = IDLE;
            else if (cnt == ALARM_LAST) state_nx = SILENT;
            else                        cnt_nx   = cnt + CNT_W'(1);
         end
         SILENT: begin
            // Any zone still tripped holds SILENT so a stuck sensor cannot re-fire the alarm.
            if (cancel)          state_nx = IDLE;
            else if (~|sensor)   state_nx = ARMED;
         end
         TEST: begin
            if (cancel) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

`ifdef MULTI_ZONE_ALARM_LATCH_EN
   logic armed_state;
   assign armed_state = (state == ARMED) || (state == PENDING) ||
                        (state == ALARM) || (state == SILENT);

   // Record survives SILENT->ARMED; only a return to IDLE or rst clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    zone_hit <= '0;
      else if (state_nx == IDLE)  zone_hit <= '0;
      else if (armed_state)       zone_hit <= zone_hit | sensor;
   end
`endif

   assign state_o = state;
   assign buzz    = (state == ALARM) || (state == TEST);
   assign armed   = (state == ARMED) || (state == PENDING) ||
                    (state == ALARM) || (state == SILENT);

endmodule

// File: tb/tb_multi_zone_alarm.sv
// Directed self-checking bench for multi_zone_alarm (default parameters).
// zone_hit checks are compiled in only when MULTI_ZONE_ALARM_LATCH_EN is defined.
module tb_multi_zone_alarm;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] sensor = '0;
   logic       start = 1'b0;
   logic       cancel = 1'b0;
   logic       test = 1'b0;
   logic       buzz;
   logic       armed;
   logic [2:0] state_o;
`ifdef MULTI_ZONE_ALARM_LATCH_EN
   logic [3:0] zone_hit;
`endif

   int checks = 0;
   int errors = 0;

   multi_zone_alarm #(
      .N_ZONES(4), .CNT_W(8), .ENTRY_DLY(50), .ALARM_TIME(200)
   ) dut (
      .clk(clk), .rst(rst), .sensor(sensor), .start(start), .cancel(cancel),
      .test(test), .buzz(buzz), .armed(armed), .state_o(state_o)
`ifdef MULTI_ZONE_ALARM_LATCH_EN
      , .zone_hit(zone_hit)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_out(input string name, input logic [2:0] st, input logic bz, input logic ar);
      checks++;
      if (state_o !== st || buzz !== bz || armed !== ar) begin
         errors++;
         $display("FAIL %s: state_o=%0d buzz=%b armed=%b, expected state_o=%0d buzz=%b armed=%b",
                  name, state_o, buzz, armed, st, bz, ar);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; sensor = '0; start = 1'b0; cancel = 1'b0; test = 1'b0;
      #12;
      rst = 1'b0;
      tick(1);
   endtask

   task automatic test_reset();
      do_reset();
      chk_out("reset", 3'd0, 1'b0, 1'b0);
`ifdef MULTI_ZONE_ALARM_LATCH_EN
      checks++;
      if (zone_hit !== 4'b0000) begin
         errors++;
         $display("FAIL reset_zone_hit: got %b expected 0000", zone_hit);
      end
`endif
   endtask

   task automatic test_entry_and_timeout();
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk_out("arm", 3'd1, 1'b0, 1'b1);
      sensor = 4'b0010;
      tick(1);
      chk_out("pending_entry", 3'd2, 1'b0, 1'b1);
      sensor = '0;
      tick(49);
      chk_out("pending_last", 3'd2, 1'b0, 1'b1);
      tick(1);
      chk_out("alarm_entry", 3'd3, 1'b1, 1'b1);
      tick(199);
      chk_out("alarm_last", 3'd3, 1'b1, 1'b1);
      tick(1);
      chk_out("silent_entry", 3'd4, 1'b0, 1'b1);
      tick(1);
      chk_out("silent_rearm", 3'd1, 1'b0, 1'b1);
   endtask

   task automatic test_cancel_pending();
      logic saw_buzz;
      saw_buzz = 1'b0;
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sensor = 4'b0010;
      tick(1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (buzz) saw_buzz = 1'b1;
      end
      chk_out("pending_cnt20", 3'd2, 1'b0, 1'b1);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      sensor = '0;
      chk_out("cancel_pending", 3'd0, 1'b0, 1'b0);
      checks++;
      if (saw_buzz !== 1'b0) begin
         errors++;
         $display("FAIL cancel_no_buzz: saw_buzz=%b expected 0", saw_buzz);
      end
`ifdef MULTI_ZONE_ALARM_LATCH_EN
      checks++;
      if (zone_hit !== 4'b0000) begin
         errors++;
         $display("FAIL cancel_zone_hit: got %b expected 0000", zone_hit);
      end
`endif
   endtask

   task automatic test_silent_hold();
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sensor = 4'b0001;
      tick(1 + 50 + 200);
      chk_out("silent_reach", 3'd4, 1'b0, 1'b1);
      tick(10);
      chk_out("silent_hold", 3'd4, 1'b0, 1'b1);
      sensor = '0;
      tick(1);
      chk_out("silent_clear", 3'd1, 1'b0, 1'b1);
   endtask

   task automatic test_start_test_priority();
      do_reset();
      start = 1'b1; test = 1'b1;
      tick(1);
      start = 1'b0; test = 1'b0;
      chk_out("start_wins", 3'd1, 1'b0, 1'b1);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk_out("cancel_armed", 3'd0, 1'b0, 1'b0);
      test = 1'b1;
      tick(1);
      test = 1'b0;
      chk_out("test_entry", 3'd5, 1'b1, 1'b0);
      start = 1'b1; sensor = 4'b1111;
      tick(5);
      chk_out("test_ignores", 3'd5, 1'b1, 1'b0);
      start = 1'b0; sensor = '0; cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      chk_out("test_cancel", 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_cancel_vs_sensor();
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sensor = 4'b0100; cancel = 1'b1;
      tick(1);
      sensor = '0; cancel = 1'b0;
      chk_out("cancel_beats_sensor", 3'd0, 1'b0, 1'b0);
   endtask

   task automatic test_zone_record();
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sensor = 4'b0010;
      tick(1);
      sensor = '0;
      tick(1);
      sensor = 4'b1000;
      tick(1);
      sensor = '0;
      chk_out("record_pending", 3'd2, 1'b0, 1'b1);
`ifdef MULTI_ZONE_ALARM_LATCH_EN
      checks++;
      if (zone_hit !== 4'b1010) begin
         errors++;
         $display("FAIL zone_hit_pending: got %b expected 1010", zone_hit);
      end
`endif
      tick(48 + 200);
      chk_out("record_silent", 3'd4, 1'b0, 1'b1);
      tick(1);
      chk_out("record_rearm", 3'd1, 1'b0, 1'b1);
`ifdef MULTI_ZONE_ALARM_LATCH_EN
      checks++;
      if (zone_hit !== 4'b1010) begin
         errors++;
         $display("FAIL zone_hit_rearm: got %b expected 1010", zone_hit);
      end
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      sensor = 4'b0001;
      tick(1 + 50 + 7);
      sensor = '0;
      chk_out("alarm_before_rst", 3'd3, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("async_rst", 3'd0, 1'b0, 1'b0);
      #3;
      rst = 1'b0;
      tick(1);
      chk_out("after_rst", 3'd0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_entry_and_timeout();
      test_cancel_pending();
      test_silent_hold();
      test_start_test_priority();
      test_cancel_vs_sensor();
      test_zone_record();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
